// File: rtl/excp_redirect.sv
// excp_redirect: commit-side exception / ERTN sequencer.
// Saves the return context, updates privilege and address-mode bits and
// issues a handshaked frontend redirect to the handler entry or return PC.
// TLB-refill exceptions use their own return context (TLBRERA / IsTLBR).
module excp_redirect #(
  parameter logic [5:0] TLBR_ECODE = 6'h3F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        commit_excp,
  input  logic [5:0]  commit_ecode,
  input  logic        commit_badv_valid,
  input  logic [31:0] commit_badv,
  input  logic        commit_ertn,
  input  logic [31:0] TLBRENTRY,
  input  logic [31:0] EENTRY,
  input  logic        redirect_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        commit_stall,
  output logic [1:0]  crmd_plv,
  output logic        crmd_ie,
  output logic        crmd_da,
  output logic        crmd_pg,
  output logic [1:0]  prmd_pplv,
  output logic        prmd_pie,
  output logic [31:0] era,
  output logic [31:0] tlbrera_pc,
  output logic        tlbr_active,
  output logic [5:0]  estat_ecode,
  output logic [31:0] badv
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] REDIR = 1'b1;

  logic [0:0] state;
  logic       in_idle;
  logic       excp_ev;
  logic       ertn_ev;
  logic       is_tlbr;

  // Events are only accepted in IDLE; anything presented during REDIR is dropped.
  assign in_idle = (state == IDLE);
  assign excp_ev = in_idle & commit_valid & commit_excp;
  assign ertn_ev = in_idle & commit_valid & commit_ertn & ~commit_excp;
  assign is_tlbr = (commit_ecode == TLBR_ECODE);

  assign redirect_valid = (state == REDIR);
  assign commit_stall   = (state == REDIR);

  // FSM and one-cycle flush pulse on event acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      flush <= 1'b0;
    end else begin
      flush <= excp_ev | ertn_ev;
      if (in_idle) begin
        if (excp_ev || ertn_ev) state <= REDIR;
      end else if (redirect_ready) begin
        state <= IDLE;
      end
    end
  end

  // Redirect target, captured at the event edge so later CSR writes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_pc <= 32'h0;
    end else if (excp_ev) begin
      redirect_pc <= is_tlbr ? {TLBRENTRY[31:6], 6'b0} : {EENTRY[31:6], 6'b0};
    end else if (ertn_ev) begin
      redirect_pc <= tlbr_active ? tlbrera_pc : era;
    end
  end

  // Privilege, interrupt-enable and saved-context bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crmd_plv  <= 2'd0;
      crmd_ie   <= 1'b0;
      prmd_pplv <= 2'd0;
      prmd_pie  <= 1'b0;
    end else if (excp_ev) begin
      prmd_pplv <= crmd_plv;
      prmd_pie  <= crmd_ie;
      crmd_plv  <= 2'd0;
      crmd_ie   <= 1'b0;
    end else if (ertn_ev) begin
      crmd_plv <= prmd_pplv;
      crmd_ie  <= prmd_pie;
    end
  end

  // Address-mode bits and the TLB-refill return context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crmd_da     <= 1'b1;
      crmd_pg     <= 1'b0;
      tlbrera_pc  <= 32'h0;
      tlbr_active <= 1'b0;
    end else if (excp_ev && is_tlbr) begin
      tlbrera_pc  <= commit_pc;
      tlbr_active <= 1'b1;
      crmd_da     <= 1'b1;
      crmd_pg     <= 1'b0;
    end else if (ertn_ev && tlbr_active) begin
      tlbr_active <= 1'b0;
      crmd_da     <= 1'b0;
      crmd_pg     <= 1'b1;
    end
  end

  // Ordinary return address, exception cause and faulting address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      era         <= 32'h0;
      estat_ecode <= 6'h0;
      badv        <= 32'h0;
    end else if (excp_ev) begin
      estat_ecode <= commit_ecode;
      if (commit_badv_valid) badv <= commit_badv;
      if (!is_tlbr) era <= commit_pc;
    end
  end

endmodule

// File: doc/excp_redirect.md
# excp_redirect

Commit-side exception/return sequencer that consumes the TLBRENTRY and EENTRY CSR values. When an instruction commits with an exception, the block saves the return context, updates the privilege and mode bits, and redirects the frontend to the correct handler entry. When an ERTN commits, it restores the saved state and redirects the frontend to the saved return PC. TLB-refill exceptions (ecode 0x3F) use a separate context: TLBRERA, the IsTLBR flag and a switch to direct-address mode.

## Interface
Parameters:
- TLBR_ECODE, 6'h3F, ecode value that selects the TLB-refill path.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- commit_valid  in  1  head-of-ROB instruction retires this cycle
- commit_pc  in  32  PC of the retiring instruction
- commit_excp  in  1  retiring instruction raised an exception
- commit_ecode  in  6  exception code
- commit_badv_valid  in  1  commit_badv is meaningful
- commit_badv  in  32  faulting virtual address
- commit_ertn  in  1  retiring instruction is ERTN
- TLBRENTRY  in  32  TLB-refill entry CSR (bits [5:0] ignored)
- EENTRY  in  32  general exception entry CSR (bits [5:0] ignored)
- redirect_ready  in  1  frontend accepts the redirect
- redirect_valid  out  1  redirect request pending
- redirect_pc  out  32  handler or return target
- flush  out  1  one-cycle pipeline flush pulse
- commit_stall  out  1  ROB must not retire
- crmd_plv  out  2  current privilege level
- crmd_ie  out  1  interrupt enable
- crmd_da  out  1  direct-address mode
- crmd_pg  out  1  paging mode
- prmd_pplv  out  2  saved PLV
- prmd_pie  out  1  saved IE
- era  out  32  exception return address
- tlbrera_pc  out  32  TLB-refill return address
- tlbr_active  out  1  TLBRERA.IsTLBR
- estat_ecode  out  6  last exception code
- badv  out  32  last bad virtual address

## Operation
- FSM states:
  - IDLE: commit_stall=0.
  - REDIR: redirect_valid=1, commit_stall=1.
- Event selection in IDLE:
  - excp_ev = commit_valid & commit_excp.
  - ertn_ev = commit_valid & commit_ertn & ~commit_excp. If both are set, the exception wins.
  - Any event moves IDLE to REDIR. REDIR returns to IDLE on the cycle redirect_ready=1 is sampled.
- On every exception:
  - Save context: prmd_pplv<=crmd_plv, prmd_pie<=crmd_ie.
  - Mask and elevate: crmd_plv<=0, crmd_ie<=0.
  - Record cause: estat_ecode<=commit_ecode.
  - badv<=commit_badv only when commit_badv_valid=1.
- TLB-refill exception (ecode==TLBR_ECODE):
  - Context: tlbrera_pc<=commit_pc, tlbr_active<=1.
  - Mode: crmd_da<=1, crmd_pg<=0.
  - Redirect: redirect_pc<={TLBRENTRY[31:6],6'b0}. era is unchanged.
- Any other exception:
  - era<=commit_pc, redirect_pc<={EENTRY[31:6],6'b0}.
  - tlbr_active and DA/PG are unchanged, so a nested ordinary exception inside the refill handler keeps IsTLBR.
- ERTN:
  - Restore: crmd_plv<=prmd_pplv, crmd_ie<=prmd_pie.
  - If tlbr_active: tlbr_active<=0, crmd_da<=0, crmd_pg<=1, redirect_pc<=tlbrera_pc.
  - Otherwise: redirect_pc<=era.
- Retirement is stalled while in REDIR. commit_valid in REDIR is ignored and must not alter any state.
- redirect_pc, and all CSR outputs, hold stable while redirect_valid=1.

## Timing
- Reset values:
  - FSM state IDLE.
  - redirect_valid=0, flush=0, redirect_pc=0.
  - crmd_plv=0, crmd_ie=0, crmd_da=1, crmd_pg=0.
  - prmd_pplv=0, prmd_pie=0.
  - era=0, tlbrera_pc=0, tlbr_active=0, estat_ecode=0, badv=0.
- Event sampled at edge N:
  - At N+1: flush=1 for exactly one cycle, redirect_valid=1, commit_stall=1, and all CSR updates visible.
- Handshake:
  - The redirect completes on the first edge with redirect_valid & redirect_ready.
  - redirect_valid=0 and commit_stall=0 from the next cycle.
  - Minimum occupancy of REDIR is 1 cycle; there is no upper bound.
- Back-to-back: a new event can be accepted on the first cycle back in IDLE, two cycles after the previous event at the earliest.
- TLBRENTRY/EENTRY are sampled only at the event edge. Later CSR writes do not affect a pending redirect.
- Reset asserted mid-REDIR: all state returns to reset values immediately. No flush or redirect is emitted after release.

## Test plan
- Reset release, then no commits: crmd_da=1, crmd_pg=0, redirect_valid=0, flush=0, commit_stall=0 indefinitely.
- TLBR exception:
  - Stimulus: TLBRENTRY=0x1C00_1040, commit_pc=0x8000_0100, ecode=0x3F, badv=0x0040_0000 (valid), redirect_ready=1.
  - Response: next cycle flush=1, redirect_pc=0x1C00_1040, tlbrera_pc=0x8000_0100, tlbr_active=1, crmd_da=1, crmd_pg=0, badv=0x0040_0000.
  - IDLE one cycle later.
- Ordinary exception:
  - Stimulus: ecode=0x0B, EENTRY=0x1C00_8000, commit_pc=0x1000, starting from crmd_plv=3, ie=1.
  - Response: redirect_pc=0x1C00_8000, era=0x1000, pplv=3, pie=1, plv=0, ie=0, tlbr_active unchanged.
- ERTN after a TLBR event: redirect_pc=previous tlbrera_pc, tlbr_active=0, crmd_da=0, crmd_pg=1. A second ERTN redirects to era.
- Held handshake: redirect_ready=0 for 5 cycles after an event.
  - Required: redirect_valid and redirect_pc stable, commit_stall=1, flush high only in the first cycle.
  - A commit_excp presented in this window changes nothing.
- Simultaneous commit_excp=1 and commit_ertn=1 is treated as an exception. Asserting rst_n=0 during REDIR restores all reset values with no further flush.
